mr_wb_arb: RTL

//  Round-robin arbiter sharing the decode stage's single regfile write port (wb_valid/wb_reg/wb_val) among NREQ

---
 rtl/mr_wb_arb_pkg.sv | 17 +
 rtl/mr_wb_arb_if.sv | 31 +++
 rtl/mr_rr_arb.sv | 40 ++++
 rtl/mr_wb_arb.sv | 109 ++++++++++
 4 files changed

// File: rtl/mr_wb_arb_pkg.sv
// rtl/mr_wb_arb_pkg.sv - shared widths, writeback request type and fixed requester indices
package mr_wb_arb_pkg;

  localparam int CFG_XLEN        = 32;
  localparam int CFG_REGSEL_BITS = 5;

  typedef struct packed {
    logic [CFG_REGSEL_BITS-1:0] rd;
    logic [CFG_XLEN-1:0]        val;
  } wb_req_t;

  typedef enum logic [0:0] {
    WBSRC_ALU  = 1'b0,
    WBSRC_LDST = 1'b1
  } e_wb_src;

endpackage

// File: rtl/mr_wb_arb_if.sv
// rtl/mr_wb_arb_if.sv - requester/writeback bundle between EX/LDST sources, the arbiter and ID
interface mr_wb_arb_if
  import mr_wb_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int XLEN     = CFG_XLEN,
  parameter int REGSEL_W = CFG_REGSEL_BITS
);
  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*REGSEL_W-1:0] req_reg;
  logic [NREQ*XLEN-1:0]     req_val;
  logic                     flush;
  logic                     wb_valid;
  logic [REGSEL_W-1:0]      wb_reg;
  logic [XLEN-1:0]          wb_val;
  logic [SRC_W-1:0]         wb_src;

  modport slave (
    input  req_valid, req_reg, req_val, flush,
    output req_ready, wb_valid, wb_reg, wb_val, wb_src
  );

  modport master (
    output req_valid, req_reg, req_val, flush,
    input  req_ready, wb_valid, wb_reg, wb_val, wb_src
  );

endinterface

// File: rtl/mr_rr_arb.sv
// rtl/mr_rr_arb.sv - generic round-robin arbiter: one-hot grant from the pointer upward, pointer moves past the winner
module mr_rr_arb #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_gnt_any
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_ptr;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    if (i_en) begin
      for (int k = 0; k < N; k++) begin
        if (!o_gnt_any && i_req[(int'(r_ptr) + k) % N]) begin
          o_gnt_any                      = 1'b1;
          o_gnt_idx                      = IDX_W'((int'(r_ptr) + k) % N);
          o_gnt[(int'(r_ptr) + k) % N]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_any) begin
      r_ptr <= (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mr_wb_arb.sv
// rtl/mr_wb_arb.sv - round-robin share of the regfile write port with registered output and flush gating
// Optional grant/stall counters when MR_WB_ARB_STATS_EN is defined.
module mr_wb_arb
  import mr_wb_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int XLEN     = CFG_XLEN,
  parameter int REGSEL_W = CFG_REGSEL_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  mr_wb_arb_if.slave        bus
`ifdef MR_WB_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0] stat_grants,
  output logic [NREQ*32-1:0] stat_stalls
`endif
);
  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]     w_gnt;
  logic [SRC_W-1:0]    w_idx;
  logic                w_any;
  logic                w_en;
  logic [REGSEL_W-1:0] w_sel_reg;
  logic [XLEN-1:0]     w_sel_val;

  logic                r_wb_valid;
  logic [REGSEL_W-1:0] r_wb_reg;
  logic [XLEN-1:0]     r_wb_val;
  logic [SRC_W-1:0]    r_wb_src;

  // Grants are suppressed both in reset and during flush, so nothing is consumed then.
  assign w_en = rst_n & ~bus.flush;

  mr_rr_arb #(.N(NREQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (bus.req_valid),
    .i_en      (w_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_idx),
    .o_gnt_any (w_any)
  );

  assign bus.req_ready = w_gnt;
  assign w_sel_reg     = bus.req_reg[int'(w_idx)*REGSEL_W +: REGSEL_W];
  assign w_sel_val     = bus.req_val[int'(w_idx)*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_val   <= '0;
      r_wb_src   <= '0;
    end else if (w_any) begin
      // x0 writes are consumed but never strobed into the regfile.
      r_wb_valid <= (w_sel_reg != '0);
      r_wb_reg   <= w_sel_reg;
      r_wb_val   <= w_sel_val;
      r_wb_src   <= w_idx;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_val   <= '0;
      r_wb_src   <= '0;
    end
  end

  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_reg   = r_wb_reg;
  assign bus.wb_val   = r_wb_val;
  assign bus.wb_src   = r_wb_src;

`ifdef MR_WB_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_grant_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (w_gnt[i] && (r_grant_cnt != '1)) begin
          r_grant_cnt <= r_grant_cnt + 32'd1;
        end
        if (bus.req_valid[i] && !w_gnt[i] && !bus.flush && (r_stall_cnt != '1)) begin
          r_stall_cnt <= r_stall_cnt + 32'd1;
        end
      end
    end

    assign stat_grants[i*32 +: 32] = r_grant_cnt;
    assign stat_stalls[i*32 +: 32] = r_stall_cnt;
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(w_gnt)) else $error("req_ready not onehot0: %b", w_gnt);
      assert ((w_gnt & ~bus.req_valid) == '0) else $error("ready without valid: %b", w_gnt);
      assert (!(bus.flush && (w_gnt != '0))) else $error("grant during flush: %b", w_gnt);
    end
  end
`endif

endmodule
